// File: rtl/ghost_lookup_arbiter.sv
// Round-robin arbiter sharing one maze wall-collision lookup among the ghost movers.
// Optional watchdog enabled by defining GHOST_LOOKUP_TIMEOUT_EN.
module ghost_lookup_arbiter #(
  parameter int unsigned NUM_GHOSTS = 4,
  parameter int unsigned GID_W      = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_GHOSTS-1:0]   req,
  input  logic [NUM_GHOSTS*10-1:0] req_x,
  input  logic [NUM_GHOSTS*9-1:0] req_y,
  input  logic [NUM_GHOSTS*2-1:0] req_dir,
  output logic [NUM_GHOSTS-1:0]   ack,
  output logic                    rsp_clear,
  output logic                    lk_valid,
  input  logic                    lk_ready,
  output logic [9:0]              lk_x,
  output logic [8:0]              lk_y,
  output logic [1:0]              lk_dir,
  input  logic                    lk_rsp_valid,
  input  logic                    lk_rsp_clear,
  output logic                    busy,
  output logic [GID_W-1:0]        grant_id,
  output logic                    timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  if ((NUM_GHOSTS < 2) || (NUM_GHOSTS > 4) || ((1 << GID_W) < NUM_GHOSTS) || (TIMEOUT == 0))
  begin : g_bad_cfg
    $error("ghost_lookup_arbiter: unsupported parameter combination");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_GHOSTS-1:0]   r_ack;
  logic [NUM_GHOSTS-1:0]   w_ack_nxt;
  logic                    r_rsp_clear;
  logic                    w_rsp_clear_nxt;
  logic                    r_lk_valid;
  logic                    w_lk_valid_nxt;
  logic [9:0]              r_lk_x;
  logic [9:0]              w_lk_x_nxt;
  logic [8:0]              r_lk_y;
  logic [8:0]              w_lk_y_nxt;
  logic [1:0]              r_lk_dir;
  logic [1:0]              w_lk_dir_nxt;
  logic                    r_busy;
  logic                    w_busy_nxt;
  logic [GID_W-1:0]        r_grant;
  logic [GID_W-1:0]        w_grant_nxt;
  logic [GID_W-1:0]        r_rr;
  logic [GID_W-1:0]        w_rr_nxt;

  logic                    w_found;
  logic [GID_W-1:0]        w_pick;
  logic [9:0]              w_pick_x;
  logic [8:0]              w_pick_y;
  logic [1:0]              w_pick_dir;
  logic [NUM_GHOSTS-1:0]   w_grant_oh;
  logic [GID_W-1:0]        w_rr_inc;

`ifdef GHOST_LOOKUP_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [WD_W-1:0]         r_wd;
  logic [WD_W-1:0]         w_wd_nxt;
  logic                    r_timeout;
  logic                    w_timeout_nxt;
`endif

  // Scan offsets from the rr pointer; the first requesting ghost wins.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_pick_x   = '0;
    w_pick_y   = '0;
    w_pick_dir = '0;
    for (int unsigned k = 0; k < NUM_GHOSTS; k++) begin
      for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
        if (!w_found && req[i] && (i == ((32'(r_rr) + k) % NUM_GHOSTS))) begin
          w_found    = 1'b1;
          w_pick     = GID_W'(i);
          w_pick_x   = req_x[10*i +: 10];
          w_pick_y   = req_y[9*i +: 9];
          w_pick_dir = req_dir[2*i +: 2];
        end
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
      w_grant_oh[i] = (r_grant == GID_W'(i));
    end
  end

  assign w_rr_inc = (r_grant == GID_W'(NUM_GHOSTS - 1)) ? '0 : (r_grant + GID_W'(1));

  always_comb begin
    w_state_nxt     = r_state;
    w_ack_nxt       = '0;
    w_rsp_clear_nxt = r_rsp_clear;
    w_lk_valid_nxt  = r_lk_valid;
    w_lk_x_nxt      = r_lk_x;
    w_lk_y_nxt      = r_lk_y;
    w_lk_dir_nxt    = r_lk_dir;
    w_grant_nxt     = r_grant;
    w_rr_nxt        = r_rr;
`ifdef GHOST_LOOKUP_TIMEOUT_EN
    w_wd_nxt        = '0;
    w_timeout_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_ISSUE;
          w_lk_valid_nxt = 1'b1;
          w_lk_x_nxt     = w_pick_x;
          w_lk_y_nxt     = w_pick_y;
          w_lk_dir_nxt   = w_pick_dir;
          w_grant_nxt    = w_pick;
        end
      end
      S_ISSUE: begin
        if (lk_ready) begin
          w_state_nxt    = S_WAIT;
          w_lk_valid_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (lk_rsp_valid) begin
          w_state_nxt     = S_RESP;
          w_rsp_clear_nxt = lk_rsp_clear;
          w_ack_nxt       = w_grant_oh;
        end
      end
      S_RESP: begin
        w_rr_nxt    = w_rr_inc;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_lk_valid_nxt = 1'b0;
      end
    endcase
`ifdef GHOST_LOOKUP_TIMEOUT_EN
    // Expiry overrides whatever ISSUE/WAIT decided this cycle.
    if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
      w_wd_nxt = r_wd + WD_W'(1);
      if (r_wd == WD_W'(TIMEOUT - 1)) begin
        w_state_nxt     = S_RESP;
        w_lk_valid_nxt  = 1'b0;
        w_rsp_clear_nxt = 1'b0;
        w_ack_nxt       = w_grant_oh;
        w_timeout_nxt   = 1'b1;
        w_wd_nxt        = '0;
      end
    end
`endif
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ack       <= '0;
      r_rsp_clear <= 1'b0;
      r_lk_valid  <= 1'b0;
      r_lk_x      <= '0;
      r_lk_y      <= '0;
      r_lk_dir    <= '0;
      r_busy      <= 1'b0;
      r_grant     <= '0;
      r_rr        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_rsp_clear <= w_rsp_clear_nxt;
      r_lk_valid  <= w_lk_valid_nxt;
      r_lk_x      <= w_lk_x_nxt;
      r_lk_y      <= w_lk_y_nxt;
      r_lk_dir    <= w_lk_dir_nxt;
      r_busy      <= w_busy_nxt;
      r_grant     <= w_grant_nxt;
      r_rr        <= w_rr_nxt;
    end
  end

`ifdef GHOST_LOOKUP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd      <= w_wd_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign ack       = r_ack;
  assign rsp_clear = r_rsp_clear;
  assign lk_valid  = r_lk_valid;
  assign lk_x      = r_lk_x;
  assign lk_y      = r_lk_y;
  assign lk_dir    = r_lk_dir;
  assign busy      = r_busy;
  assign grant_id  = r_grant;

endmodule

// File: tb/tb_ghost_lookup_arbiter.sv
// Directed self-checking bench for ghost_lookup_arbiter (watchdog steps need GHOST_LOOKUP_TIMEOUT_EN).
module tb_ghost_lookup_arbiter;

  localparam int unsigned NG = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NG-1:0] req = '0;
  logic [NG*10-1:0] req_x = '0;
  logic [NG*9-1:0]  req_y = '0;
  logic [NG*2-1:0]  req_dir = '0;
  logic [NG-1:0] ack;
  logic          rsp_clear;
  logic          lk_valid;
  logic          lk_ready = 1'b0;
  logic [9:0]    lk_x;
  logic [8:0]    lk_y;
  logic [1:0]    lk_dir;
  logic          lk_rsp_valid = 1'b0;
  logic          lk_rsp_clear = 1'b0;
  logic          busy;
  logic [1:0]    grant_id;
  logic          timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] gx [NG] = '{10'd511, 10'd333, 10'd200, 10'd777};
  logic [8:0] gy [NG] = '{9'd5, 9'd300, 9'd146, 9'd480};
  logic [1:0] gd [NG] = '{2'd3, 2'd1, 2'd0, 2'd2};

  ghost_lookup_arbiter #(
    .NUM_GHOSTS(NG),
    .GID_W(2),
    .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_x(req_x),
    .req_y(req_y),
    .req_dir(req_dir),
    .ack(ack),
    .rsp_clear(rsp_clear),
    .lk_valid(lk_valid),
    .lk_ready(lk_ready),
    .lk_x(lk_x),
    .lk_y(lk_y),
    .lk_dir(lk_dir),
    .lk_rsp_valid(lk_rsp_valid),
    .lk_rsp_clear(lk_rsp_clear),
    .busy(busy),
    .grant_id(grant_id),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_time_limit: observed no finish, expected finish before 100000");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_coords();
    for (int g = 0; g < NG; g++) begin
      req_x[10*g +: 10] = gx[g];
      req_y[9*g +: 9]   = gy[g];
      req_dir[2*g +: 2] = gd[g];
    end
  endtask

  initial begin
    logic [3:0] exp_oh;
    int         g;

    load_coords();

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rsp_clear", 32'(rsp_clear), 32'h0);
    check("rst_lk_valid", 32'(lk_valid), 32'h0);
    check("rst_lk_x", 32'(lk_x), 32'h0);
    check("rst_lk_y", 32'(lk_y), 32'h0);
    check("rst_lk_dir", 32'(lk_dir), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b1;

    // Single request from ghost 2, minimum latency
    lk_ready = 1'b1;
    req = 4'b0100;
    tick();
    check("single_lk_valid", 32'(lk_valid), 32'h1);
    check("single_lk_x", 32'(lk_x), 32'd200);
    check("single_lk_y", 32'(lk_y), 32'd146);
    check("single_lk_dir", 32'(lk_dir), 32'h0);
    check("single_grant", 32'(grant_id), 32'd2);
    check("single_busy", 32'(busy), 32'h1);
    tick();
    check("single_accept_valid", 32'(lk_valid), 32'h0);
    check("single_wait_ack", 32'(ack), 32'h0);
    lk_rsp_valid = 1'b1;
    lk_rsp_clear = 1'b1;
    tick();
    check("single_ack", 32'(ack), 32'b0100);
    check("single_rsp_clear", 32'(rsp_clear), 32'h1);
    check("single_resp_busy", 32'(busy), 32'h1);
    check("single_timeout", 32'(timeout), 32'h0);
    lk_rsp_valid = 1'b0;
    req = '0;
    tick();
    check("single_ack_drop", 32'(ack), 32'h0);
    check("single_idle_busy", 32'(busy), 32'h0);

    // Fairness: all four ghosts requesting from a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      g = n % NG;
      exp_oh = 4'b0001 << g;
      tick();
      check("fair_grant", 32'(grant_id), 32'(g));
      check("fair_lk_valid", 32'(lk_valid), 32'h1);
      check("fair_lk_x", 32'(lk_x), 32'(gx[g]));
      check("fair_lk_y", 32'(lk_y), 32'(gy[g]));
      check("fair_lk_dir", 32'(lk_dir), 32'(gd[g]));
      tick();
      check("fair_accept", 32'(lk_valid), 32'h0);
      lk_rsp_valid = 1'b1;
      lk_rsp_clear = n[0];
      tick();
      check("fair_ack", 32'(ack), 32'(exp_oh));
      check("fair_rsp_clear", 32'(rsp_clear), 32'(n[0]));
      lk_rsp_valid = 1'b0;
      tick();
      check("fair_ack_drop", 32'(ack), 32'h0);
      check("fair_idle", 32'(busy), 32'h0);
    end
    req = '0;

    // Backpressure: lk_ready low for 5 cycles in ISSUE, coordinates latched
    req = 4'b0010;
    lk_ready = 1'b0;
    tick();
    check("bp_lk_valid", 32'(lk_valid), 32'h1);
    check("bp_grant", 32'(grant_id), 32'd1);
    req_x[10 +: 10] = 10'd9;
    req_y[9 +: 9] = 9'd17;
    req_dir[2 +: 2] = 2'd2;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("bp_hold_valid", 32'(lk_valid), 32'h1);
      check("bp_hold_x", 32'(lk_x), 32'd333);
      check("bp_hold_y", 32'(lk_y), 32'd300);
      check("bp_hold_dir", 32'(lk_dir), 32'd1);
    end
    lk_ready = 1'b1;
    tick();
    check("bp_leave_issue", 32'(lk_valid), 32'h0);
    check("bp_busy", 32'(busy), 32'h1);
    lk_rsp_valid = 1'b1;
    lk_rsp_clear = 1'b0;
    tick();
    check("bp_ack", 32'(ack), 32'b0010);
    check("bp_rsp_clear", 32'(rsp_clear), 32'h0);
    lk_rsp_valid = 1'b0;
    req = '0;
    tick();
    check("bp_idle", 32'(busy), 32'h0);
    load_coords();

    // Spurious responses in IDLE and ISSUE
    lk_rsp_valid = 1'b1;
    lk_rsp_clear = 1'b1;
    tick();
    check("spur_idle_busy", 32'(busy), 32'h0);
    check("spur_idle_ack", 32'(ack), 32'h0);
    check("spur_idle_valid", 32'(lk_valid), 32'h0);
    lk_rsp_valid = 1'b0;
    req = 4'b0001;
    lk_ready = 1'b0;
    tick();
    check("spur_grant", 32'(grant_id), 32'd0);
    req = '0;
    lk_rsp_valid = 1'b1;
    tick();
    check("spur_issue_valid", 32'(lk_valid), 32'h1);
    check("spur_issue_ack", 32'(ack), 32'h0);
    lk_rsp_valid = 1'b0;
    lk_ready = 1'b1;
    tick();
    check("spur_accept", 32'(lk_valid), 32'h0);
    tick();
    tick();
    check("spur_wait_busy", 32'(busy), 32'h1);
    check("spur_wait_ack", 32'(ack), 32'h0);
    lk_rsp_valid = 1'b1;
    lk_rsp_clear = 1'b1;
    tick();
    check("spur_ack", 32'(ack), 32'b0001);
    check("spur_rsp_clear", 32'(rsp_clear), 32'h1);
    lk_rsp_valid = 1'b0;
    tick();
    check("spur_idle_after", 32'(busy), 32'h0);

    // Reset abort in WAIT; rr pointer is 1 here, so ghost 2 wins first
    req = 4'b0100;
    lk_ready = 1'b1;
    tick();
    check("abort_grant", 32'(grant_id), 32'd2);
    tick();
    check("abort_in_wait", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ack", 32'(ack), 32'h0);
    check("abort_lk_valid", 32'(lk_valid), 32'h0);
    check("abort_grant_rst", 32'(grant_id), 32'h0);
    req = '0;
    tick();
    rst = 1'b1;
    lk_rsp_valid = 1'b1;
    lk_rsp_clear = 1'b1;
    tick();
    check("abort_late_busy", 32'(busy), 32'h0);
    check("abort_late_ack", 32'(ack), 32'h0);
    lk_rsp_valid = 1'b0;
    tick();
    check("abort_late_ack2", 32'(ack), 32'h0);
    req = 4'b1111;
    tick();
    check("abort_next_grant", 32'(grant_id), 32'd0);
    check("abort_next_valid", 32'(lk_valid), 32'h1);
    req = '0;
    tick();
    lk_rsp_valid = 1'b1;
    lk_rsp_clear = 1'b1;
    tick();
    check("abort_next_ack", 32'(ack), 32'b0001);
    lk_rsp_valid = 1'b0;
    tick();
    check("abort_next_idle", 32'(busy), 32'h0);

`ifdef GHOST_LOOKUP_TIMEOUT_EN
    // Watchdog: accepted request, response never arrives; rsp_clear is 1 beforehand
    req = 4'b0010;
    lk_ready = 1'b1;
    tick();
    check("to_issue", 32'(lk_valid), 32'h1);
    for (int n = 0; n < 9; n++) begin
      tick();
      check("to_pre_pulse", 32'(timeout), 32'h0);
      check("to_pre_ack", 32'(ack), 32'h0);
    end
    tick();
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_ack", 32'(ack), 32'b0010);
    check("to_rsp_clear", 32'(rsp_clear), 32'h0);
    check("to_lk_valid", 32'(lk_valid), 32'h0);
    req = '0;
    lk_rsp_valid = 1'b1;
    lk_rsp_clear = 1'b1;
    tick();
    check("to_pulse_drop", 32'(timeout), 32'h0);
    check("to_late_ack", 32'(ack), 32'h0);
    check("to_late_busy", 32'(busy), 32'h0);
    lk_rsp_valid = 1'b0;
`else
    // Without the watchdog a stalled lookup simply waits
    req = 4'b0010;
    lk_ready = 1'b1;
    tick();
    req = '0;
    repeat (20) tick();
    check("nowd_busy", 32'(busy), 32'h1);
    check("nowd_ack", 32'(ack), 32'h0);
    check("nowd_timeout", 32'(timeout), 32'h0);
    lk_rsp_valid = 1'b1;
    lk_rsp_clear = 1'b0;
    tick();
    check("nowd_ack_late", 32'(ack), 32'b0010);
    check("nowd_rsp_clear", 32'(rsp_clear), 32'h0);
    lk_rsp_valid = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
